// File: rtl/conv1d_pkg.sv
// Shared types and defaults for the 1-D convolution MAC sequencer.
package conv1d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    FOLD,
    WRITE,
    DONE
  } state_t;

  localparam int DEF_KERNEL_LEN  = 3;
  localparam int DEF_NUM_KERNELS = 4;
  localparam int DEF_IN_LEN      = 16;
  localparam int DEF_OUT_LEN     = DEF_IN_LEN - DEF_KERNEL_LEN + 1;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/conv1d_loop_counter.sv
// Nested tap / output-position / kernel counters with terminal-count flags.
// pos_next/k_next give the position the pass moves to after the current output.
module conv1d_loop_counter
  import conv1d_pkg::*;
#(
  parameter int KERNEL_LEN  = DEF_KERNEL_LEN,
  parameter int NUM_KERNELS = DEF_NUM_KERNELS,
  parameter int OUT_LEN     = DEF_OUT_LEN,
  parameter int TAP_W       = clog2_min1(KERNEL_LEN),
  parameter int POS_W       = clog2_min1(OUT_LEN),
  parameter int KI_W        = clog2_min1(NUM_KERNELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_tap,
  input  logic             inc_pos,
  output logic [TAP_W-1:0] tap,
  output logic [POS_W-1:0] pos,
  output logic [KI_W-1:0]  k,
  output logic [POS_W-1:0] pos_next,
  output logic [KI_W-1:0]  k_next,
  output logic             last_tap,
  output logic             last_pos,
  output logic             last_kernel
);

  assign last_tap    = (tap == TAP_W'(KERNEL_LEN - 1));
  assign last_pos    = (pos == POS_W'(OUT_LEN - 1));
  assign last_kernel = (k == KI_W'(NUM_KERNELS - 1));

  // After the final output everything wraps to zero so no address overflows.
  always_comb begin
    pos_next = last_pos ? '0 : pos + POS_W'(1);
    k_next   = k;
    if (last_pos) begin
      k_next = last_kernel ? '0 : k + KI_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap <= '0;
      pos <= '0;
      k   <= '0;
    end else if (clear) begin
      tap <= '0;
      pos <= '0;
      k   <= '0;
    end else begin
      if (inc_tap) begin
        tap <= last_tap ? '0 : tap + TAP_W'(1);
      end
      if (inc_pos) begin
        pos <= pos_next;
        k   <= k_next;
      end
    end
  end

endmodule

// File: rtl/conv1d_mac_sequencer.sv
// Sequences a single MAC through every kernel/position/tap of a 1-D convolution.
// Loop order is kernel, then position, then tap; read addresses lead data by one cycle.
module conv1d_mac_sequencer
  import conv1d_pkg::*;
#(
  parameter int KERNEL_LEN  = DEF_KERNEL_LEN,
  parameter int NUM_KERNELS = DEF_NUM_KERNELS,
  parameter int IN_LEN      = DEF_IN_LEN,
  parameter int XA_W        = clog2_min1(IN_LEN),
  parameter int WA_W        = clog2_min1(NUM_KERNELS * KERNEL_LEN),
  parameter int OA_W        = clog2_min1(NUM_KERNELS * (IN_LEN - KERNEL_LEN + 1)),
  parameter int KI_W        = clog2_min1(NUM_KERNELS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XA_W-1:0] x_addr,
  output logic [WA_W-1:0] w_addr,
  output logic [KI_W-1:0] bias_addr,
  output logic            mac_clear,
  output logic            mac_valid,
  output logic            out_wr_en,
  output logic [OA_W-1:0] out_addr
);

  localparam int OUT_LEN = IN_LEN - KERNEL_LEN + 1;
  localparam int TAP_W   = clog2_min1(KERNEL_LEN);
  localparam int POS_W   = clog2_min1(OUT_LEN);

  state_t state, state_next;

  logic             cnt_clear, inc_tap, inc_pos;
  logic [TAP_W-1:0] tap;
  logic [POS_W-1:0] pos, pos_next;
  logic [KI_W-1:0]  k, k_next;
  logic             last_tap, last_pos, last_kernel;
  logic             pass_end;

  conv1d_loop_counter #(
    .KERNEL_LEN (KERNEL_LEN),
    .NUM_KERNELS(NUM_KERNELS),
    .OUT_LEN    (OUT_LEN),
    .TAP_W      (TAP_W),
    .POS_W      (POS_W),
    .KI_W       (KI_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .inc_tap    (inc_tap),
    .inc_pos    (inc_pos),
    .tap        (tap),
    .pos        (pos),
    .k          (k),
    .pos_next   (pos_next),
    .k_next     (k_next),
    .last_tap   (last_tap),
    .last_pos   (last_pos),
    .last_kernel(last_kernel)
  );

  assign pass_end = last_pos && last_kernel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The MAC accumulates whenever clear and valid are both low, so clear is
  // held high everywhere except the tap and fold cycles.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    mac_clear  = 1'b1;
    mac_valid  = 1'b0;
    out_wr_en  = 1'b0;
    cnt_clear  = 1'b0;
    inc_tap    = 1'b0;
    inc_pos    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_clear  = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: state_next = MAC;
      MAC: begin
        mac_clear = 1'b0;
        inc_tap   = 1'b1;
        if (last_tap) state_next = FOLD;
      end
      FOLD: begin
        mac_clear  = 1'b0;
        mac_valid  = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        out_wr_en  = 1'b1;
        inc_pos    = 1'b1;
        state_next = pass_end ? DONE : MAC;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address shown in cycle t is the one whose data the MAC consumes in t+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_addr <= '0;
      w_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_addr <= '0;
            w_addr <= '0;
          end
        end
        CLEAR: begin
          x_addr <= x_addr + XA_W'(1);
          w_addr <= w_addr + WA_W'(1);
        end
        MAC: begin
          if (int'(tap) < KERNEL_LEN - 2) begin
            x_addr <= x_addr + XA_W'(1);
            w_addr <= w_addr + WA_W'(1);
          end
        end
        FOLD: begin
          x_addr <= XA_W'(pos_next);
          w_addr <= WA_W'(int'(k_next) * KERNEL_LEN);
        end
        WRITE: begin
          if (!pass_end) begin
            x_addr <= x_addr + XA_W'(1);
            w_addr <= w_addr + WA_W'(1);
          end
        end
        default: begin
          x_addr <= x_addr;
          w_addr <= w_addr;
        end
      endcase
    end
  end

  assign bias_addr = k;
  assign out_addr  = OA_W'(int'(k) * OUT_LEN + int'(pos));

endmodule

// File: tb/tb_conv1d_mac_sequencer.sv
// Bench: sequencer driving a behavioural MAC and registered-read memories.
module tb_conv1d_mac_sequencer;

  localparam int KL = 3;
  localparam int NK = 2;
  localparam int IL = 8;
  localparam int OL = IL - KL + 1;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] x_addr;
  logic [2:0] w_addr;
  logic [0:0] bias_addr;
  logic       mac_clear;
  logic       mac_valid;
  logic       out_wr_en;
  logic [3:0] out_addr;

  conv1d_mac_sequencer #(
    .KERNEL_LEN (KL),
    .NUM_KERNELS(NK),
    .IN_LEN     (IL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .x_addr   (x_addr),
    .w_addr   (w_addr),
    .bias_addr(bias_addr),
    .mac_clear(mac_clear),
    .mac_valid(mac_valid),
    .out_wr_en(out_wr_en),
    .out_addr (out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int x_mem[IL];
  int w_mem[NK*KL];
  int bias_mem[NK];
  int x_dat, w_dat, acc, psum;

  always @(posedge clk) begin
    x_dat <= x_mem[x_addr];
    w_dat <= w_mem[w_addr];
    if (mac_clear) begin
      acc <= 0;
    end else if (mac_valid) begin
      acc  <= acc + bias_mem[bias_addr];
      psum <= acc + bias_mem[bias_addr];
    end else begin
      acc <= acc + w_dat * x_dat;
    end
  end

  typedef struct {
    int addr;
    int data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int b0;
    int b1;
    int extra_start;
    int exp0;
    int exp1_first;
    bit trace;
  } pass_t;
  pass_t tbl[3];

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit trace_en = 1'b0;
  int trace_cnt = 0;
  int trace_x[3];
  int trace_w[3];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (trace_cnt > 0) begin
      chk("trace_x_addr", int'(x_addr), trace_x[3-trace_cnt]);
      chk("trace_w_addr", int'(w_addr), trace_w[3-trace_cnt]);
      chk("trace_mac_ctl", int'({mac_clear, mac_valid}), 0);
      trace_cnt--;
    end
    if (out_wr_en) begin
      wr_cnt++;
      if (trace_en && out_addr == 4'd7) begin
        chk("trace_pre_x_addr", int'(x_addr), 2);
        chk("trace_pre_w_addr", int'(w_addr), 3);
        trace_cnt = 3;
      end
      if (sb.size() == 0) begin
        chk("unexpected_write", int'(out_addr), -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", int'(out_addr), e.addr);
        chk("wr_data", psum, e.data);
      end
    end
    if (done) done_cnt++;
  end

  task automatic push_pass(input int exp0, input int exp1_first, input int n_out);
    for (int i = 0; i < n_out; i++) begin
      exp_t e;
      e.addr = i;
      e.data = (i < OL) ? exp0 : exp1_first + 3 * (i - OL);
      sb.push_back(e);
    end
  endtask

  task automatic run_pass(input pass_t p);
    int done_cyc;
    done_cyc = -1;
    bias_mem[0] = p.b0;
    bias_mem[1] = p.b1;
    push_pass(p.exp0, p.exp1_first, NK*OL);
    wr_cnt = 0;
    done_cnt = 0;
    trace_en = p.trace;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
      end
      if (c == p.extra_start) start = 1'b1;
      if (c == p.extra_start + 1) start = 1'b0;
      if (done && done_cyc < 0) done_cyc = c;
    end
    chk("done_cycle", done_cyc, 62);
    chk("done_count", done_cnt, 1);
    chk("write_count", wr_cnt, NK*OL);
    chk("sb_empty", sb.size(), 0);
    chk("idle_after_pass", int'(busy), 0);
    trace_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < IL; i++) x_mem[i] = i + 1;
    w_mem[0] = 1; w_mem[1] = 0; w_mem[2] = -1;
    w_mem[3] = 1; w_mem[4] = 1; w_mem[5] = 1;
    bias_mem[0] = 0; bias_mem[1] = 0;
    trace_x[0] = 3; trace_x[1] = 4; trace_x[2] = 4;
    trace_w[0] = 4; trace_w[1] = 5; trace_w[2] = 5;

    tbl[0] = '{b0: 0,   b1: 0,    extra_start: 0,  exp0: -2, exp1_first: 6,   trace: 1'b1};
    tbl[1] = '{b0: 0,   b1: 0,    extra_start: 20, exp0: -2, exp1_first: 6,   trace: 1'b0};
    tbl[2] = '{b0: 100, b1: -100, extra_start: 0,  exp0: 98, exp1_first: -94, trace: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", int'({busy, mac_clear, mac_valid, out_wr_en, done}), 5'b01000);
    chk("rst_addr", int'({x_addr, w_addr, bias_addr, out_addr}), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ctl", int'({busy, mac_clear, out_wr_en, done}), 4'b0100);
    end

    foreach (tbl[i]) run_pass(tbl[i]);

    // Reset during the fold of output 5: only outputs 0..4 may be written.
    bias_mem[0] = 0;
    bias_mem[1] = 0;
    push_pass(-2, 6, 5);
    wr_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("fold_of_out5", int'({mac_valid, out_addr}), {1'b1, 4'd5});
    reset = 1'b1;
    #1;
    chk("busy_in_reset", int'(busy), 0);
    chk("ctl_in_reset", int'({out_wr_en, done, mac_clear}), 3'b001);
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    chk("rst_mid_writes", wr_cnt, 5);
    chk("rst_mid_done", done_cnt, 0);
    chk("rst_mid_sb_empty", sb.size(), 0);

    run_pass(tbl[0]);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/conv1d_mac_sequencer.md
Name: conv1d_mac_sequencer

Overview:
- Controller that sequences one mac_unit through a full multi-kernel 1-D convolution.
- Issues input and weight memory read addresses, and drives the MAC's clear and valid controls.
- Writes each finished output sample to the output memory.
- Sits between the top-level start/done handshake and the MAC datapath. Loop order: kernel (outer), then output position, then tap (inner).

Parameters:
- KERNEL_LEN, 3, taps per kernel (>=2)
- NUM_KERNELS, 4, number of kernels
- IN_LEN, 16, input samples (>= KERNEL_LEN)
- OUT_LEN, IN_LEN-KERNEL_LEN+1, derived localparam, outputs per kernel
- XA_W, $clog2(IN_LEN), input address width
- WA_W, $clog2(NUM_KERNELS*KERNEL_LEN), weight address width
- OA_W, $clog2(NUM_KERNELS*OUT_LEN), output address width
- KI_W, $clog2(NUM_KERNELS) (min 1), kernel index width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a convolution pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass
- x_addr  out  XA_W  input memory read address (registered-read memory, 1-cycle latency)
- w_addr  out  WA_W  weight memory read address (same latency)
- bias_addr  out  KI_W  current kernel index; selects the psum_in bias
- mac_clear  out  1  drives mac_unit clear
- mac_valid  out  1  drives mac_unit valid (fold psum_in, publish psum_out)
- out_wr_en  out  1  output memory write strobe
- out_addr  out  OA_W  output memory write address, = kernel*OUT_LEN + pos

Behaviour:
- Reset values: state=IDLE; counters k, pos, tap = 0; all addresses 0; mac_clear=1; mac_valid=0; out_wr_en=0; busy=0; done=0.
- The MAC accumulates w*x on every cycle where clear=0 and valid=0. The sequencer therefore holds mac_clear=1 in every state that is neither MAC nor FOLD.
- IDLE:
  - mac_clear=1.
  - start=1 -> CLEAR; k=pos=tap=0.
- CLEAR (1 cycle):
  - mac_clear=1.
  - Issue tap-0 address: x_addr=pos, w_addr=k*KERNEL_LEN.
  - -> MAC.
- MAC (KERNEL_LEN cycles, tap=0..KERNEL_LEN-1):
  - mac_clear=0, mac_valid=0.
  - Memory data for tap t is present in cycle t.
  - Issue the tap t+1 address in cycle t. On the last tap, hold the previous address.
  - After the last tap -> FOLD; tap=0.
- FOLD (1 cycle):
  - mac_valid=1, mac_clear=0.
  - MAC adds the bias and registers psum_out at the end of the cycle.
  - -> WRITE.
- WRITE (1 cycle):
  - out_wr_en=1, out_addr=k*OUT_LEN+pos. Output memory captures psum_out at the closing edge.
  - mac_clear=1 in the same cycle; the write sees the pre-clear value.
  - Advance pos, or wrap pos to 0 and advance k.
  - Issue the tap-0 address for the next output in this cycle.
  - If the last output is done -> DONE, otherwise -> MAC (CLEAR is skipped).
- DONE (1 cycle):
  - done=1, mac_clear=1.
  - -> IDLE.
- Cycle cost of a pass: 1 + NUM_KERNELS*OUT_LEN*(KERNEL_LEN+2) + 1 from start acceptance to done.
- start while busy: ignored, no queueing. start held high through DONE: a new pass starts from IDLE on the following edge.
- Wrap: pos wraps at OUT_LEN-1, k terminates at NUM_KERNELS-1. Address arithmetic never exceeds declared widths.
- Reset mid-pass: immediate return to IDLE with reset values. No write strobe or done pulse is generated. A partial output memory is left as-is.
- All outputs are registered or decoded from the state register. There is no combinational path from start to any output.

Decomposition:
- Package conv1d_pkg:
  - state enum (IDLE, CLEAR, MAC, FOLD, WRITE, DONE)
  - default KERNEL_LEN, NUM_KERNELS, IN_LEN
  - derived OUT_LEN
  - width helper constants
- One natural sub-module, conv1d_loop_counter: nested tap/pos/kernel counters with inc/clear inputs and last_tap/last_pos/last_kernel flags. The FSM stays in conv1d_mac_sequencer.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, mac_clear=1, out_wr_en=0, done=0 throughout.
- Full pass with KERNEL_LEN=3, NUM_KERNELS=2, IN_LEN=8, real mac_unit plus memories, x=1..8, w0={1,0,-1}, w1={1,1,1}, bias=0:
  - out_wr_en asserted exactly 12 times with out_addr 0..11.
  - Kernel 0 outputs all -2; kernel 1 outputs 6, 9, 12, 15, 18, 21.
  - done pulses once at cycle 62 after start acceptance.
- Address trace check on the same pass, output 2 of kernel 1: MAC-cycle w_addr sequence 4,5,5 and x_addr sequence 3,4,4, preceded by x_addr=2, w_addr=3 in the prior WRITE.
- start pulsed again at cycle 20 of a pass -> ignored; exactly 12 writes and one done pulse.
- reset asserted during FOLD of output 5 -> busy=0 in the same cycle, no further out_wr_en, no done pulse. A following start produces a complete, correct pass.
- Bias check: bias={100,-100}, same data -> kernel 0 outputs 98; kernel 1 outputs -94 .. -79.
